// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle for bcd_countdown_timer: load/start/pause/tick requests
// in, packed BCD MM:SS and status flags out.
interface bcd_countdown_timer_if;
    logic       tick;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic [7:0] min_out;
    logic [7:0] sec_out;
    logic       running;
    logic       done;
    logic       load_err;
    logic       alarm;

    modport master (
        output tick, load, load_min, load_sec, start, pause,
        input  min_out, sec_out, running, done, load_err, alarm
    );

    modport slave (
        input  tick, load, load_min, load_sec, start, pause,
        output min_out, sec_out, running, done, load_err, alarm
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Loadable MM:SS packed-BCD countdown timer with expiry pulse.
// Optional expiry alarm enabled by defining COUNTDOWN_ALARM_EN.
module bcd_countdown_timer #(
    parameter logic [7:0]  MIN_MAX     = 8'h59,
    parameter int unsigned ALARM_TICKS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t     state, state_next;
    logic [7:0] min_q, sec_q, min_next, sec_next;
    logic [7:0] dec_min, dec_sec;
    logic       running_q, done_q, load_err_q;
    logic       done_next, load_err_next;
    logic       load_ok, accept_load, is_zero, at_one;

    assign load_ok = (bus.load_min[7:4] <= 4'd9) && (bus.load_min[3:0] <= 4'd9) &&
                     (bus.load_sec[7:4] <= 4'd5) && (bus.load_sec[3:0] <= 4'd9) &&
                     (bus.load_min <= MIN_MAX);
    assign accept_load = bus.load && load_ok && (state != RUN);
    assign is_zero     = (min_q == 8'h00) && (sec_q == 8'h00);
    assign at_one      = (min_q == 8'h00) && (sec_q == 8'h01);

    // One-second BCD decrement; only used when the value is nonzero.
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q[3:0] != 4'd0) begin
            dec_sec[3:0] = sec_q[3:0] - 4'd1;
        end else if (sec_q[7:4] != 4'd0) begin
            dec_sec = {sec_q[7:4] - 4'd1, 4'd9};
        end else begin
            dec_sec = 8'h59;
            if (min_q[3:0] != 4'd0) dec_min[3:0] = min_q[3:0] - 4'd1;
            else                    dec_min = {min_q[7:4] - 4'd1, 4'd9};
        end
    end

    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next    = state;
        min_next      = min_q;
        sec_next      = sec_q;
        done_next     = 1'b0;
        load_err_next = 1'b0;
        if (bus.load) begin
            if (accept_load) begin
                min_next   = bus.load_min;
                sec_next   = bus.load_sec;
                state_next = IDLE;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (bus.pause) begin
            if (state == RUN) state_next = PAUSED;
        end else if (bus.start) begin
            if ((state == IDLE && !is_zero) || state == PAUSED) state_next = RUN;
        end else if (bus.tick && state == RUN && !is_zero) begin
            min_next = dec_min;
            sec_next = dec_sec;
            if (at_one) begin
                state_next = EXPIRED;
                done_next  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state      <= state_next;
            min_q      <= min_next;
            sec_q      <= sec_next;
            running_q  <= (state_next == RUN);
            done_q     <= done_next;
            load_err_q <= load_err_next;
        end
    end

`ifdef COUNTDOWN_ALARM_EN
    localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

    logic [AW-1:0] alarm_cnt;
    logic          alarm_q;
    logic          alarm_clear;

    assign alarm_clear = accept_load || (bus.start && !bus.load && !bus.pause);

    // Counts tick pulses after expiry; the expiring tick itself is not counted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alarm_q   <= 1'b0;
            alarm_cnt <= '0;
        end else if (done_next) begin
            alarm_q   <= 1'b1;
            alarm_cnt <= AW'(ALARM_TICKS);
        end else if (alarm_clear) begin
            alarm_q   <= 1'b0;
            alarm_cnt <= '0;
        end else if (alarm_q && bus.tick) begin
            if (alarm_cnt == AW'(1)) alarm_q <= 1'b0;
            alarm_cnt <= alarm_cnt - AW'(1);
        end
    end

    assign bus.alarm = alarm_q;
`else
    assign bus.alarm = 1'b0;
`endif

    assign bus.min_out  = min_q;
    assign bus.sec_out  = sec_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

endmodule
